// File: rtl/ibex_pkg.sv
// Shared types for the fetch line buffer: FSM state encoding and a saturating counter helper.
package ibex_pkg;

  typedef enum logic {
    LB_IDLE   = 1'b0,
    LB_REFILL = 1'b1
  } line_buf_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] lb_sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ibex_fetch_refill_ctrl.sv
// Memory-side sequencer for a line refill: issue count, in-flight count, response slot tracking
// and word address generation.
module ibex_fetch_refill_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned LINE_WORDS      = 4,
  parameter int unsigned MEM_OUTSTANDING = 2,
  localparam int unsigned IDX_W          = $clog2(LINE_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [31:0]      base_i,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  output logic [IDX_W-1:0] rsp_idx_o,
  output logic             rsp_last_o
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OUT_W = $clog2(MEM_OUTSTANDING + 1);

  logic [CNT_W-1:0] issue_q;
  logic [OUT_W-1:0] inflight_q;
  logic [IDX_W-1:0] rx_q;
  logic             all_issued;
  logic             gnt_fire;
  logic             rsp_fire;

  assign all_issued = (issue_q == CNT_W'(LINE_WORDS));
  assign mem_req_o  = active_i & ~all_issued & (inflight_q < OUT_W'(MEM_OUTSTANDING));
  assign gnt_fire   = mem_req_o & mem_gnt_i;
  assign rsp_fire   = active_i & mem_rvalid_i;
  // Address only moves on a grant, so it stays stable while a request waits.
  assign mem_addr_o = base_i | 32'({issue_q[IDX_W-1:0], 2'b00});
  assign rsp_idx_o  = rx_q;
  assign rsp_last_o = rsp_fire & (rx_q == IDX_W'(LINE_WORDS - 1));

  // Issue, in-flight and response counters; cleared when a new refill starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_q    <= '0;
      inflight_q <= '0;
      rx_q       <= '0;
    end else if (start_i) begin
      issue_q    <= '0;
      inflight_q <= '0;
      rx_q       <= '0;
    end else begin
      if (gnt_fire) issue_q <= issue_q + CNT_W'(1);
      if (rsp_fire) rx_q <= rx_q + IDX_W'(1);
      case ({gnt_fire, rsp_fire})
        2'b10:   inflight_q <= inflight_q + OUT_W'(1);
        2'b01:   inflight_q <= inflight_q - OUT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_fetch_line_buffer.sv
// Single-line instruction buffer between the prefetch buffer and instruction memory.
// Optional hit/miss performance counters are built when IBEX_LINE_BUF_PERF_EN is defined.
module ibex_fetch_line_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned LINE_WORDS      = 4,
  parameter int unsigned MEM_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
`ifdef IBEX_LINE_BUF_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  line_buf_state_e  state_q;
  logic             line_valid_q;
  logic             poison_q;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      line_q [LINE_WORDS];
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             hit;
  logic             miss_start;
  logic [31:0]      line_base;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_last;
  logic             unused_addr_lsb;

  assign req_tag         = core_addr_i[31:IDX_W+2];
  assign req_idx         = core_addr_i[IDX_W+1:2];
  assign unused_addr_lsb = ^core_addr_i[1:0];
  assign hit             = line_valid_q & (tag_q == req_tag) & ~flush_i;
  assign core_gnt_o      = (state_q == LB_IDLE) & core_req_i;
  assign miss_start      = core_gnt_o & ~hit;
  assign line_base       = {tag_q, {(IDX_W + 2){1'b0}}};

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_err_o    = err_q;
  assign busy_o        = (state_q != LB_IDLE) | rvalid_q;

  ibex_fetch_refill_ctrl #(
    .LINE_WORDS     (LINE_WORDS),
    .MEM_OUTSTANDING(MEM_OUTSTANDING)
  ) u_refill_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (miss_start),
    .active_i    (state_q == LB_REFILL),
    .base_i      (line_base),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .rsp_idx_o   (rsp_idx),
    .rsp_last_o  (rsp_last)
  );

  // Line storage: refill responses land in their word slot in arrival order.
  always_ff @(posedge clk_i) begin
    if ((state_q == LB_REFILL) && mem_rvalid_i) begin
      line_q[rsp_idx] <= mem_rdata_i;
    end
  end

  // Control FSM with tag/valid tracking and the registered core response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= LB_IDLE;
      line_valid_q <= 1'b0;
      poison_q     <= 1'b0;
      tag_q        <= '0;
      idx_q        <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        LB_IDLE: begin
          if (flush_i) line_valid_q <= 1'b0;
          if (core_req_i) begin
            if (hit) begin
              rvalid_q <= 1'b1;
              rdata_q  <= line_q[req_idx];
              err_q    <= 1'b0;
            end else begin
              tag_q        <= req_tag;
              idx_q        <= req_idx;
              line_valid_q <= 1'b0;
              // A flush racing the miss also keeps the refilled line from being trusted.
              poison_q     <= flush_i;
              state_q      <= LB_REFILL;
            end
          end
        end
        LB_REFILL: begin
          if (flush_i) poison_q <= 1'b1;
          if (mem_rvalid_i) begin
            if (mem_err_i) poison_q <= 1'b1;
            if (rsp_idx == idx_q) begin
              rvalid_q <= 1'b1;
              rdata_q  <= mem_rdata_i;
              err_q    <= mem_err_i;
            end
          end
          if (rsp_last) begin
            state_q      <= LB_IDLE;
            line_valid_q <= ~(poison_q | flush_i | mem_err_i);
          end
        end
        default: state_q <= LB_IDLE;
      endcase
    end
  end

`ifdef IBEX_LINE_BUF_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating counts of granted hits and misses; flush does not clear them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (core_gnt_o) begin
      if (hit) hit_cnt_q <= lb_sat_inc(hit_cnt_q);
      else     miss_cnt_q <= lb_sat_inc(miss_cnt_q);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_fetch_line_buffer.sv
// Bench for ibex_fetch_line_buffer: transaction-level model of the single-line buffer plus an
// in-order memory with random grant/response timing and error injection.
module tb_ibex_fetch_line_buffer;

  localparam int unsigned LW = 4;
  localparam int unsigned MO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_gnt_o;
  logic [31:0] core_addr_i = '0;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;
  logic        busy_o;
`ifdef IBEX_LINE_BUF_PERF_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  always #5 clk = ~clk;

  ibex_fetch_line_buffer #(.LINE_WORDS(LW), .MEM_OUTSTANDING(MO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush_i),
    .core_req_i   (core_req_i),
    .core_gnt_o   (core_gnt_o),
    .core_addr_i  (core_addr_i),
    .core_rvalid_o(core_rvalid_o),
    .core_rdata_o (core_rdata_o),
    .core_err_o   (core_err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .busy_o       (busy_o)
`ifdef IBEX_LINE_BUF_PERF_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        err;
  } mrsp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory: granted-but-unanswered words, answered strictly in order.
  mrsp_t mq[$];
  int    gnt_prob = 100;
  int    rsp_prob = 100;
  int    err_prob = 0;
  bit    ferr_en  = 1'b0;
  logic [31:0] ferr_addr = '0;

  // Model of the buffer, kept as "what line is held" plus refill progress.
  bit          m_refill, m_valid, m_poison, m_rv, m_er;
  logic [31:0] m_base, m_line, m_rd;
  int          m_issued, m_returned, m_idx;
  int unsigned m_hits, m_misses;

  // Observation logs for the directed literal checks.
  logic [31:0] gaddr[$];
  logic [31:0] rlog[$];
  logic        elog[$];
  int          max_infl;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] line_of(logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_refill = 0; m_valid = 0; m_poison = 0; m_rv = 0; m_er = 0;
    m_base = '0; m_line = '0; m_rd = '0;
    m_issued = 0; m_returned = 0; m_idx = 0;
    m_hits = 0; m_misses = 0;
    mq.delete();
  endtask

  // Asynchronous reset applied 1 time unit after a rising edge; returns at posedge+1.
  task automatic do_reset();
    core_req_i = 0; flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 32'(core_rvalid_o), 0);
    chk("rst_rdata", core_rdata_o, 0);
    chk("rst_err", 32'(core_err_o), 0);
    chk("rst_gnt", 32'(core_gnt_o), 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
`ifdef IBEX_LINE_BUF_PERF_EN
    chk("rst_hit_cnt", hit_cnt_o, 0);
    chk("rst_miss_cnt", miss_cnt_o, 0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: check registered outputs, drive inputs, check combinational outputs,
  // advance the model across the coming edge. Entered and left at posedge+1.
  task automatic cycle(input logic req, input logic [31:0] addr, input logic flush);
    mrsp_t       r;
    bit          exp_req, rsp_now, hit, rv_n;
    logic [31:0] exp_addr;

    chk("core_rvalid", 32'(core_rvalid_o), 32'(m_rv));
    if (m_rv) begin
      chk("core_rdata", core_rdata_o, m_rd);
      chk("core_err", 32'(core_err_o), 32'(m_er));
    end
    if (core_rvalid_o) begin
      rlog.push_back(core_rdata_o);
      elog.push_back(core_err_o);
    end
    chk("busy", 32'(busy_o), 32'(m_refill | m_rv));
`ifdef IBEX_LINE_BUF_PERF_EN
    chk("hit_cnt", hit_cnt_o, m_hits);
    chk("miss_cnt", miss_cnt_o, m_misses);
`endif

    core_req_i  = req;
    core_addr_i = addr;
    flush_i     = flush;
    mem_gnt_i   = ($urandom_range(99) < gnt_prob);
    rsp_now     = (mq.size() > 0) && ($urandom_range(99) < rsp_prob);
    mem_rvalid_i = rsp_now;
    if (rsp_now) begin
      mem_rdata_i = mem_word(mq[0].addr);
      mem_err_i   = mq[0].err;
    end else begin
      mem_rdata_i = $urandom;
      mem_err_i   = 1'($urandom);
    end
    #1;

    exp_req  = m_refill && (m_issued < LW) && (mq.size() < MO);
    exp_addr = m_base + 32'(m_issued * 4);
    chk("core_gnt", 32'(core_gnt_o), 32'(!m_refill && req));
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    if (exp_req) chk("mem_addr", mem_addr_o, exp_addr);

    rv_n = 0;
    if (!m_refill) begin
      if (req) begin
        hit = m_valid && (m_line == line_of(addr)) && !flush;
        if (hit) begin
          rv_n = 1; m_rd = mem_word(addr & ~32'h3); m_er = 0; m_hits++;
        end else begin
          m_refill = 1; m_base = line_of(addr); m_line = m_base;
          m_idx = int'((addr >> 2) % LW); m_poison = flush;
          m_issued = 0; m_returned = 0; m_valid = 0; m_misses++;
        end
      end
      if (flush) m_valid = 0;
    end else begin
      if (flush) m_poison = 1;
      if (rsp_now) begin
        r = mq.pop_front();
        if (m_returned == m_idx) begin
          rv_n = 1; m_rd = mem_word(r.addr); m_er = r.err;
        end
        if (r.err) m_poison = 1;
        m_returned++;
        if (m_returned == LW) begin
          m_refill = 0; m_valid = !m_poison;
        end
      end
      if (exp_req && mem_gnt_i) begin
        r.addr = exp_addr;
        r.err  = (ferr_en && (exp_addr == ferr_addr)) || ($urandom_range(99) < err_prob);
        mq.push_back(r);
        gaddr.push_back(exp_addr);
        m_issued++;
        if (mq.size() > max_infl) max_infl = mq.size();
      end
    end
    m_rv = rv_n;

    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_refill || m_rv) && n < 400) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    if (m_refill || m_rv) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: refill still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic clear_logs();
    gaddr.delete(); rlog.delete(); elog.delete(); max_infl = 0;
  endtask

  logic [31:0] cur_line;

  initial begin
    model_reset();
    clear_logs();
    do_reset();

    // 1: miss at 0x100 fills the line in order and returns word 0
    clear_logs();
    cycle(1'b1, 32'h100, 1'b0);
    wait_idle();
    chk("t1_nreq", 32'(gaddr.size()), 4);
    chk("t1_a0", gaddr[0], 32'h100);
    chk("t1_a1", gaddr[1], 32'h104);
    chk("t1_a2", gaddr[2], 32'h108);
    chk("t1_a3", gaddr[3], 32'h10C);
    chk("t1_data", rlog[0], 32'hDEAD_0100);

    // 2: back-to-back hits on the held line
    clear_logs();
    cycle(1'b1, 32'h104, 1'b0);
    cycle(1'b1, 32'h108, 1'b0);
    cycle(1'b1, 32'h10E, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t2_nresp", 32'(rlog.size()), 3);
    chk("t2_d1", rlog[0], 32'hDEAD_0104);
    chk("t2_d2", rlog[1], 32'hDEAD_0108);
    chk("t2_d3", rlog[2], 32'hDEAD_010C);
    chk("t2_no_mem", 32'(gaddr.size()), 0);

    // 3: delayed grant holds the address; outstanding limit stops issue
    clear_logs();
    gnt_prob = 0; rsp_prob = 0;
    cycle(1'b1, 32'h208, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_addr_hold", mem_addr_o, 32'h200);
      chk("t3_req_hold", 32'(mem_req_o), 1);
      cycle(1'b0, 32'h0, 1'b0);
    end
    gnt_prob = 100;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("t3_max_inflight", 32'(max_infl), 2);
    chk("t3_req_stall", 32'(mem_req_o), 0);
    rsp_prob = 100;
    wait_idle();
    chk("t3_data", rlog[0], 32'hDEAD_0208);

    // 4: flush during refill still returns the word but leaves the line invalid
    clear_logs();
    cycle(1'b1, 32'h300, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    wait_idle();
    chk("t4_drained", 32'(gaddr.size()), 4);
    chk("t4_data", rlog[0], 32'hDEAD_0300);
    clear_logs();
    cycle(1'b1, 32'h304, 1'b0);
    chk("t4_miss_busy", 32'(busy_o), 1);
    wait_idle();
    chk("t4_refetch", 32'(gaddr.size()), 4);

    // 5: error on another word is hidden but invalidates; error on the requested word is reported
    clear_logs();
    ferr_en = 1'b1; ferr_addr = 32'h40C;
    cycle(1'b1, 32'h400, 1'b0);
    wait_idle();
    chk("t5_err_hidden", 32'(elog[0]), 0);
    chk("t5_data", rlog[0], 32'hDEAD_0400);
    clear_logs();
    cycle(1'b1, 32'h404, 1'b0);
    wait_idle();
    chk("t5_refetch", 32'(gaddr.size()), 4);
    clear_logs();
    ferr_addr = 32'h504;
    cycle(1'b1, 32'h504, 1'b0);
    wait_idle();
    chk("t5_err_seen", 32'(elog[0]), 1);
    ferr_en = 1'b0;

    // 6: reset mid-refill abandons it
    cycle(1'b1, 32'h600, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    do_reset();
    clear_logs();
    cycle(1'b1, 32'h600, 1'b0);
    wait_idle();
    chk("t6_refetch_n", 32'(gaddr.size()), 4);
    chk("t6_refetch_a", gaddr[0], 32'h600);

    // Random traffic with varying memory timing, errors and flushes
    cur_line = 32'h1000;
    err_prob = 4;
    for (int blk = 0; blk < 15; blk++) begin
      gnt_prob = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 70 : 100);
      rsp_prob = (blk % 4 == 0) ? 25 : ((blk % 4 == 1) ? 60 : 100);
      for (int c = 0; c < 200; c++) begin
        logic        rq;
        logic        fl;
        if ($urandom_range(99) >= 70) cur_line = 32'h1000 + 32'($urandom_range(0, 7)) * 32'(LW * 4);
        rq = ($urandom_range(99) < 60);
        fl = ($urandom_range(99) < 3);
        cycle(rq, cur_line | 32'($urandom_range(0, LW * 4 - 1)), fl);
      end
      if (blk == 7) do_reset();
    end
    err_prob = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
